// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame scheduler and its burst-error injector.
package viterbi_pkg;

    localparam logic [1:0] ERR_MASK  = 2'b10;
    localparam int         ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/viterbi_burst_inj.sv
// Periodic burst-error injector: every 2^BURST_PERIOD_LOG2 valid symbols, the next
// BURST_LEN valid symbols get ERR_MASK applied; corrupted symbols are counted (saturating).
module viterbi_burst_inj
    import viterbi_pkg::*;
#(
    parameter int BURST_PERIOD_LOG2 = 5,
    parameter int BURST_LEN         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_valid_i,
    output logic [1:0]           mask_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int LEN_W = $clog2(BURST_LEN + 1);

    logic [BURST_PERIOD_LOG2-1:0] sym_cnt_q, sym_cnt_d;
    logic                         active_q, active_d;
    logic [LEN_W-1:0]             rem_q, rem_d;
    logic [ERR_CNT_W-1:0]         err_cnt_q, err_cnt_d;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        sym_cnt_d = sym_cnt_q;
        active_d  = active_q;
        rem_d     = rem_q;
        err_cnt_d = err_cnt_q;
        mask_o    = 2'b00;
        if (sym_valid_i) begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            if (active_q) begin
                mask_o = ERR_MASK;
                rem_d  = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    active_d = 1'b0;
                end
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end else if (sym_cnt_q == '1) begin
                // Trigger on the last symbol of a period; a trigger mid-burst is ignored.
                active_d = 1'b1;
                rem_d    = LEN_W'(BURST_LEN);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q <= '0;
            active_q  <= 1'b0;
            rem_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            active_q  <= active_d;
            rem_q     <= rem_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count_o = err_cnt_q;

endmodule

// File: rtl/viterbi_frame_sched.sv
// Frame scheduler for the encoder/channel/Viterbi loop. Define VITERBI_ERR_INJECT_EN to
// build in the periodic burst-error injector on the channel stage.
module viterbi_frame_sched
    import viterbi_pkg::*;
#(
    parameter int DATA_W            = 16,
    parameter int TAIL_LEN          = 2,
    parameter int DEC_LAT           = 24,
    parameter int BURST_PERIOD_LOG2 = 5,
    parameter int BURST_LEN         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_valid_i,
    input  logic [DATA_W-1:0]    frame_data_i,
    output logic                 frame_ready_o,
    output logic                 enc_en_o,
    output logic                 enc_bit_o,
    input  logic [1:0]           enc_sym_i,
    input  logic                 enc_valid_i,
    output logic                 dec_en_o,
    output logic [1:0]           chan_sym_o,
    input  logic                 dec_bit_i,
    output logic                 out_valid_o,
    output logic [DATA_W-1:0]    out_data_o,
    output logic                 busy_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int CYC_W = $clog2(DEC_LAT + DATA_W + 1);
    localparam logic [CYC_W-1:0] SEND_LAST  = CYC_W'(DATA_W - 1);
    localparam logic [CYC_W-1:0] FLUSH_LAST = CYC_W'(DATA_W + TAIL_LEN - 1);
    localparam logic [CYC_W-1:0] WAIT_LAST  = CYC_W'(DEC_LAT - 1);
    localparam logic [CYC_W-1:0] CAP_LAST   = CYC_W'(DEC_LAT + DATA_W - 1);
    localparam bit               HAS_WAIT   = (DEC_LAT > DATA_W + TAIL_LEN);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("DATA_W must be at least 2");
    end
    if (TAIL_LEN < 1) begin : g_bad_tail
        $error("TAIL_LEN must be at least 1");
    end
    if (DEC_LAT < DATA_W + TAIL_LEN) begin : g_bad_dec_lat
        $error("DEC_LAT must be at least DATA_W+TAIL_LEN");
    end
    if (BURST_LEN < 1 || BURST_LEN > (1 << BURST_PERIOD_LOG2) - 1) begin : g_bad_burst
        $error("BURST_LEN must be in 1..2^BURST_PERIOD_LOG2-1");
    end

    sched_state_e        state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                dec_en_q;
    logic [1:0]          chan_sym_q;
    logic [1:0]          mask;

    // The payload shift register is reused to collect decoded bits during CAPTURE.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        shift_d    = shift_q;
        out_data_d = out_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    state_d = ST_SEND;
                    cyc_d   = '0;
                    shift_d = frame_data_i;
                end
            end
            ST_SEND: begin
                cyc_d   = cyc_q + 1'b1;
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                if (cyc_q == SEND_LAST) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == FLUSH_LAST) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cyc_d   = cyc_q + 1'b1;
                shift_d = {shift_q[DATA_W-2:0], dec_bit_i};
                if (cyc_q == CAP_LAST) begin
                    out_data_d = {shift_q[DATA_W-2:0], dec_bit_i};
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            shift_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            shift_q    <= shift_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef VITERBI_ERR_INJECT_EN
    viterbi_burst_inj #(
        .BURST_PERIOD_LOG2 (BURST_PERIOD_LOG2),
        .BURST_LEN         (BURST_LEN)
    ) u_burst_inj (
        .clk         (clk),
        .rst         (rst),
        .sym_valid_i (enc_valid_i),
        .mask_o      (mask),
        .err_count_o (err_count_o)
    );
`else
    assign mask        = 2'b00;
    assign err_count_o = '0;
`endif

    // Channel stage runs every cycle regardless of the scheduler state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_en_q   <= 1'b0;
            chan_sym_q <= 2'b00;
        end else begin
            dec_en_q   <= enc_valid_i;
            chan_sym_q <= enc_sym_i ^ mask;
        end
    end

    assign frame_ready_o = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign enc_en_o      = (state_q == ST_SEND) || (state_q == ST_FLUSH);
    assign enc_bit_o     = (state_q == ST_SEND) && shift_q[DATA_W-1];
    assign out_valid_o   = (state_q == ST_DONE);
    assign out_data_o    = out_data_q;
    assign dec_en_o      = dec_en_q;
    assign chan_sym_o    = chan_sym_q;

endmodule

// File: tb/tb_viterbi_frame_sched.sv
// Self-checking bench: frame-level model plus channel/burst model, directed frames.
module tb_viterbi_frame_sched;

    localparam int DATA_W    = 16;
    localparam int TAIL_LEN  = 2;
    localparam int DEC_LAT   = 24;
    localparam int BP_LOG2   = 5;
    localparam int BURST_LEN = 5;
    localparam int PERIOD    = 1 << BP_LOG2;
    localparam int OUT_K     = DEC_LAT + DATA_W + 1;
    localparam int ENC_SPAN  = DATA_W + TAIL_LEN;
`ifdef VITERBI_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_valid_i = 1'b0;
    logic [DATA_W-1:0] frame_data_i = '0;
    logic              frame_ready_o, enc_en_o, enc_bit_o, dec_en_o, out_valid_o, busy_o;
    logic [1:0]        enc_sym_i, chan_sym_o;
    logic              enc_valid_i, dec_bit_i;
    logic [DATA_W-1:0] out_data_o;
    logic [15:0]       err_count_o;

    viterbi_frame_sched #(
        .DATA_W(DATA_W), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT),
        .BURST_PERIOD_LOG2(BP_LOG2), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_valid_i(frame_valid_i), .frame_data_i(frame_data_i), .frame_ready_o(frame_ready_o),
        .enc_en_o(enc_en_o), .enc_bit_o(enc_bit_o), .enc_sym_i(enc_sym_i), .enc_valid_i(enc_valid_i),
        .dec_en_o(dec_en_o), .chan_sym_o(chan_sym_o), .dec_bit_i(dec_bit_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .busy_o(busy_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Environment: K=3 rate-1/2 encoder, or a free-running symbol pattern in continuous mode.
    logic       cont_mode = 1'b0;
    logic [1:0] enc_st = 2'b00;
    logic [1:0] sym_pat = 2'b00;
    always @(posedge clk) begin
        if (enc_en_o) enc_st <= {enc_st[0], enc_bit_o};
        sym_pat <= sym_pat + 2'd1;
    end
    always_comb begin
        enc_valid_i = cont_mode | enc_en_o;
        if (cont_mode) enc_sym_i = sym_pat;
        else if (enc_en_o) enc_sym_i = {enc_bit_o ^ enc_st[0] ^ enc_st[1], enc_bit_o ^ enc_st[1]};
        else enc_sym_i = 2'b00;
    end

    // Ideal decoder: encoder input bit delayed by exactly DEC_LAT cycles.
    logic [DEC_LAT-1:0] hist = '0;
    always @(posedge clk) hist <= {hist[DEC_LAT-2:0], enc_bit_o};
    assign dec_bit_i = hist[DEC_LAT-1];

    // Event monitor for directed checks.
    int          ov_cyc[$];
    logic [15:0] ov_data[$];
    int          acc_cnt = 0;
    always @(negedge clk) begin
        if (!rst && out_valid_o) begin
            ov_cyc.push_back(tb_cyc);
            ov_data.push_back(out_data_o);
        end
        if (!rst && frame_ready_o && frame_valid_i) acc_cnt++;
    end

    // Reference model: frame timeline from the accept cycle, and burst positions by symbol index.
    bit          m_act = 1'b0;
    int          m_e = 0;
    logic [15:0] m_data = '0, m_held = '0;
    int          m_sym_n = 0;
    int          m_err = 0;
    logic [1:0]  e_chan = 2'b00;
    logic        e_den = 1'b0;
    always @(negedge clk) begin
        int k;
        bit idle_now, corr;
        if (rst) begin
            check("rst_ready", frame_ready_o, 1);
            check("rst_busy", busy_o, 0);
            check("rst_enc_en", enc_en_o, 0);
            check("rst_enc_bit", enc_bit_o, 0);
            check("rst_out_valid", out_valid_o, 0);
            check("rst_out_data", out_data_o, 0);
            check("rst_err", err_count_o, 0);
            check("rst_chan", chan_sym_o, 0);
            check("rst_dec_en", dec_en_o, 0);
            m_act = 1'b0; m_held = '0; m_sym_n = 0; m_err = 0; e_chan = 2'b00; e_den = 1'b0;
        end else begin
            k = tb_cyc - m_e;
            idle_now = !m_act;
            check("chan_sym", chan_sym_o, e_chan);
            check("dec_en", dec_en_o, e_den);
            check("err_count", err_count_o, m_err);
            check("ready", frame_ready_o, idle_now);
            check("busy", busy_o, !idle_now);
            check("enc_en", enc_en_o, m_act && k <= ENC_SPAN);
            check("enc_bit", enc_bit_o, (m_act && k <= DATA_W) ? m_data[DATA_W-k] : 1'b0);
            check("out_valid", out_valid_o, m_act && k == OUT_K);
            check("out_data", out_data_o, (m_act && k == OUT_K) ? m_data : m_held);
            if (m_act && k == OUT_K) begin
                m_held = m_data;
                m_act  = 1'b0;
            end
            if (idle_now && frame_valid_i) begin
                m_act = 1'b1; m_e = tb_cyc; m_data = frame_data_i;
            end
            corr = INJ && enc_valid_i && m_sym_n >= PERIOD && (m_sym_n % PERIOD) < BURST_LEN;
            if (enc_valid_i) m_sym_n++;
            e_chan = enc_sym_i ^ (corr ? 2'b10 : 2'b00);
            e_den  = enc_valid_i;
            if (corr && m_err < 'hFFFF) m_err++;
        end
    end

    task automatic offer(input logic [15:0] d, output int e);
        e = -1;
        @(posedge clk); #1;
        frame_valid_i = 1'b1; frame_data_i = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_ready_o) begin e = tb_cyc; break; end
        end
        check("accept_seen", e >= 0, 1);
        @(posedge clk); #1;
        frame_valid_i = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output logic [15:0] data);
        bit seen = 1'b0;
        cyc = -1; data = '0;
        for (int i = 0; i < 200; i++) begin
            if (ov_cyc.size() > 0) begin
                cyc = ov_cyc.pop_front(); data = ov_data.pop_front(); seen = 1'b1; break;
            end
            @(negedge clk); #1;
        end
        check("out_valid_seen", seen, 1);
    endtask

    initial begin
        int e1, e2, oc, n_ov, n_acc, en_seen;
        logic [15:0] od;

        // Reset, then 50 idle cycles.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        en_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (enc_en_o) en_seen++;
        end
        check("idle_enc_en_activity", en_seen, 0);
        check("idle_ready", frame_ready_o, 1);
        check("idle_busy", busy_o, 0);

        // Loopback of a single frame.
        offer(16'hA5C3, e1);
        wait_out(oc, od);
        check("loop_latency", oc - e1, 41);
        check("loop_data", od, 16'hA5C3);
        check("loop_err", err_count_o, 0);

        // Back-to-back with valid held high.
        ov_cyc.delete(); ov_data.delete();
        n_acc = acc_cnt;
        e1 = -1; e2 = -1;
        @(posedge clk); #1;
        frame_valid_i = 1'b1; frame_data_i = 16'h0001;
        for (int i = 0; i < 100 && e1 < 0; i++) begin
            @(negedge clk);
            if (frame_ready_o) e1 = tb_cyc;
        end
        @(posedge clk); #1;
        frame_data_i = 16'hFFFF;
        for (int i = 0; i < 100 && e2 < 0; i++) begin
            @(negedge clk);
            if (frame_ready_o) e2 = tb_cyc;
        end
        @(posedge clk); #1;
        frame_valid_i = 1'b0;
        check("b2b_spacing", e2 - e1, 42);
        wait_out(oc, od);
        check("b2b_first_data", od, 16'h0001);
        check("b2b_first_latency", oc - e1, 41);
        wait_out(oc, od);
        check("b2b_second_data", od, 16'hFFFF);
        repeat (10) @(posedge clk);
        check("b2b_accepts", acc_cnt - n_acc, 2);

        // Reset mid-frame, then a clean frame.
        offer(16'h5A5A, e1);
        while (tb_cyc < e1 + 10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_enc_en", enc_en_o, 0);
        check("midrst_ready", frame_ready_o, 1);
        @(posedge clk); #1 rst = 1'b0;
        n_ov = ov_cyc.size();
        repeat (60) @(posedge clk);
        check("midrst_no_out", ov_cyc.size() - n_ov, 0);
        offer(16'h1234, e1);
        wait_out(oc, od);
        check("after_rst_data", od, 16'h1234);
        check("after_rst_latency", oc - e1, 41);

`ifdef VITERBI_ERR_INJECT_EN
        // Continuous symbols from reset: bursts at 32..36, 64..68, 96..100.
        @(posedge clk); #1;
        rst = 1'b1; cont_mode = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (37) @(posedge clk);
        #1 check("inj_err_after_36", err_count_o, 5);
        repeat (32) @(posedge clk);
        #1 check("inj_err_after_68", err_count_o, 10);
        force dut.u_burst_inj.err_cnt_q = 16'hFFFE;
        m_err = 'hFFFE;
        #1 release dut.u_burst_inj.err_cnt_q;
        repeat (32) @(posedge clk);
        #1 check("inj_err_saturate", err_count_o, 16'hFFFF);
        cont_mode = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
